pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control-transfer sequencer feeding the pipelined PC unit. It decodes the IF-stage instruction and tracks each instruction's class through RF and EX. It drives every per-stage strobe the PC unit consumes: BEQ/BNE/J/JAL/JR/LW in IF, BEQ/BNE/JR in RF, and BEQ/BNE in EX. It also tells the IF/RF pipeline register when to load a bubble instead of the held, stale IF word.

## Interface
- CNT_W, 16, width of statistics counters
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  inst_if holds a fetched word
- inst_if  in  32  instruction word in IF
- alu_zero_ex  in  1  ALU zero flag of the EX-stage instruction
- beq_if, bne_if, j_if, jal_if, jr_if, lw_if  out  1 each  IF-stage class strobes; asserted only for a fresh word
- beq_rf, bne_rf, jr_rf  out  1 each  RF-stage class strobes
- beq_ex, bne_ex  out  1 each  EX-stage class strobes
- rf_bubble  out  1  IF/RF register loads NOP this edge
- if_stale  out  1  inst_if is a held replay and must be ignored
- br_taken_ex  out  1  (beq_ex & alu_zero_ex) | (bne_ex & ~alu_zero_ex)
- stall_cnt, taken_cnt  out  CNT_W each  statistics (see Configuration)

## Operation
- Decode: opcode 0x04 BEQ, 0x05 BNE, 0x02 J, 0x03 JAL, 0x23 LW, 0x2B SW, and 0x00 with funct 0x08 JR. Any other opcode is ALU.
- Class registers cls_rf and cls_ex, 4 bits each. Each edge: cls_ex <= cls_rf; cls_rf <= NOP if rf_bubble, else the decoded IF class.
- rf_bubble = if_stale | ~if_valid.
- FSM states: RUN, BR_RF, BR_EX, JR_RF, LD_RF.
  - RUN, fresh BEQ/BNE -> BR_RF. Fresh JR -> JR_RF. Fresh LW -> LD_RF. Anything else stays in RUN.
  - BR_RF -> BR_EX. BR_EX -> RUN. JR_RF -> RUN. LD_RF -> RUN. All of these are unconditional.
- if_stale = (state != RUN).
- IF strobes = decode & if_valid & ~if_stale.
- RF strobes decode cls_rf. EX strobes decode cls_ex.
- J/JAL: redirect in IF with no stall and no bubble.
- Net effect on the PC unit's stall condition:
  - branch holds the PC in IF and RF, then resolves in EX (2 bubbles)
  - JR holds the PC in IF, then redirects in RF (1 bubble)
  - LW holds the PC in IF only (1 bubble, unconditional load-use gap)
- if_valid low in RUN: bubble and no strobes, state unchanged. if_valid is ignored in the other states.

## Timing
- Reset (async assert): state RUN, cls_rf = cls_ex = NOP, counters 0.
  - All outputs 0, except rf_bubble = 1 while if_valid is low.
- Deassertion is sampled on the next clk edge. First fresh decode is in the first cycle after release.
- IF strobes, if_stale and rf_bubble are combinational from inst_if, if_valid and state.
- RF/EX strobes are registered: exactly 1 and 2 cycles after the fresh IF strobe.
- BEQ at cycle 0:
  - beq_if in c0, beq_rf in c1, beq_ex in c2
  - if_stale in c1–c2
  - next fresh IF in c3
- JR at cycle 0: jr_if in c0, jr_rf and if_stale in c1, fresh in c2.
- LW at cycle 0: lw_if in c0, if_stale in c1, fresh in c2.
- A control instruction arriving while stale is never decoded. It is refetched after redirect.
- Reset mid-sequence aborts it. No strobe survives reset.

## Configuration
- PIPE_HAZARD_STATS_EN defined:
  - stall_cnt increments each cycle any of beq_if, bne_if, beq_rf, bne_rf, jr_if, lw_if is high
  - taken_cnt increments each cycle br_taken_ex is high
  - both saturate at all-ones and do not wrap
- Undefined: no counter flops; stall_cnt and taken_cnt are tied to 0. The ports remain.

## Structure
- Package pipe_hazard_pkg holds:
  - class localparams CLS_NOP, ALU, LW, SW, BEQ, BNE, J, JAL, JR (4-bit)
  - opcode/funct constants
  - FSM state encoding
- Sub-module pipe_inst_classify: combinational word-to-class decoder. It is instantiated once for IF; RF and EX decode from the stored class.

## Test plan
- Reset held, then release with ALU words -> all strobes 0, rf_bubble 0, counters 0.
- BEQ (0x1000_0003) at c0 with alu_zero_ex=1 in c2:
  - beq_if c0, beq_rf c1, beq_ex and br_taken_ex c2
  - rf_bubble c1–c2
  - stall_cnt=2, taken_cnt=1
- BNE with alu_zero_ex=1 -> bne_ex high in c2, br_taken_ex 0, taken_cnt unchanged.
- JR $ra (0x03E0_0008) -> jr_if c0, jr_rf c1, one bubble, fresh in c2.
- LW then J back-to-back:
  - lw_if c0, stale c1
  - J word re-presented at c2 gives j_if with no bubble
  - held J word in c1 gives no j_if
- rst_n asserted during BR_RF -> next cycle state RUN, beq_rf/beq_ex never assert, counters 0.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - instruction classes, opcode/funct codes and FSM encoding for pipe_hazard_ctrl
package pipe_hazard_pkg;

    typedef logic [3:0] cls_t;

    localparam cls_t CLS_NOP = 4'd0;
    localparam cls_t CLS_ALU = 4'd1;
    localparam cls_t CLS_LW  = 4'd2;
    localparam cls_t CLS_SW  = 4'd3;
    localparam cls_t CLS_BEQ = 4'd4;
    localparam cls_t CLS_BNE = 4'd5;
    localparam cls_t CLS_J   = 4'd6;
    localparam cls_t CLS_JAL = 4'd7;
    localparam cls_t CLS_JR  = 4'd8;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_BR_RF = 3'd1;
    localparam logic [2:0] ST_BR_EX = 3'd2;
    localparam logic [2:0] ST_JR_RF = 3'd3;
    localparam logic [2:0] ST_LD_RF = 3'd4;

    function automatic logic is_branch(input cls_t c);
        return (c == CLS_BEQ) || (c == CLS_BNE);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - IF word input and per-stage strobe bundle of pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             if_valid;
    logic [31:0]      inst_if;
    logic             alu_zero_ex;
    logic             beq_if, bne_if, j_if, jal_if, jr_if, lw_if;
    logic             beq_rf, bne_rf, jr_rf;
    logic             beq_ex, bne_ex;
    logic             rf_bubble;
    logic             if_stale;
    logic             br_taken_ex;
    logic [CNT_W-1:0] stall_cnt, taken_cnt;

    modport master (
        output if_valid, inst_if, alu_zero_ex,
        input  beq_if, bne_if, j_if, jal_if, jr_if, lw_if,
        input  beq_rf, bne_rf, jr_rf, beq_ex, bne_ex,
        input  rf_bubble, if_stale, br_taken_ex, stall_cnt, taken_cnt
    );

    modport slave (
        input  if_valid, inst_if, alu_zero_ex,
        output beq_if, bne_if, j_if, jal_if, jr_if, lw_if,
        output beq_rf, bne_rf, jr_rf, beq_ex, bne_ex,
        output rf_bubble, if_stale, br_taken_ex, stall_cnt, taken_cnt
    );
endinterface

// File: rtl/pipe_inst_classify.sv
// rtl/pipe_inst_classify.sv - combinational instruction word to class decoder
module pipe_inst_classify
    import pipe_hazard_pkg::*;
(
    input  logic [31:0] inst,
    output cls_t        cls
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = inst[31:26];
    assign funct         = inst[5:0];
    assign unused_fields = ^inst[25:6];

    always_comb begin
        cls = CLS_ALU;
        case (opcode)
            OP_BEQ:     cls = CLS_BEQ;
            OP_BNE:     cls = CLS_BNE;
            OP_J:       cls = CLS_J;
            OP_JAL:     cls = CLS_JAL;
            OP_LW:      cls = CLS_LW;
            OP_SW:      cls = CLS_SW;
            OP_SPECIAL: cls = (funct == FN_JR) ? CLS_JR : CLS_ALU;
            default:    cls = CLS_ALU;
        endcase
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - control-transfer sequencer; optional statistics via PIPE_HAZARD_STATS_EN
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    logic [2:0] state_q, state_d;
    cls_t       cls_if, cls_rf_q, cls_ex_q;
    logic       stale, fresh;

    pipe_inst_classify u_classify (
        .inst (bus.inst_if),
        .cls  (cls_if)
    );

    assign stale = (state_q != ST_RUN);
    assign fresh = bus.if_valid & ~stale;

    assign bus.if_stale  = stale;
    assign bus.rf_bubble = ~fresh;

    assign bus.beq_if = fresh & (cls_if == CLS_BEQ);
    assign bus.bne_if = fresh & (cls_if == CLS_BNE);
    assign bus.j_if   = fresh & (cls_if == CLS_J);
    assign bus.jal_if = fresh & (cls_if == CLS_JAL);
    assign bus.jr_if  = fresh & (cls_if == CLS_JR);
    assign bus.lw_if  = fresh & (cls_if == CLS_LW);

    assign bus.beq_rf = (cls_rf_q == CLS_BEQ);
    assign bus.bne_rf = (cls_rf_q == CLS_BNE);
    assign bus.jr_rf  = (cls_rf_q == CLS_JR);
    assign bus.beq_ex = (cls_ex_q == CLS_BEQ);
    assign bus.bne_ex = (cls_ex_q == CLS_BNE);

    assign bus.br_taken_ex = (bus.beq_ex & bus.alu_zero_ex) | (bus.bne_ex & ~bus.alu_zero_ex);

    // Only a fresh word may start a sequence; every hold state drains back to RUN on its own.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (fresh && is_branch(cls_if))  state_d = ST_BR_RF;
                else if (fresh && cls_if == CLS_JR) state_d = ST_JR_RF;
                else if (fresh && cls_if == CLS_LW) state_d = ST_LD_RF;
                else                                 state_d = ST_RUN;
            end
            ST_BR_RF: state_d = ST_BR_EX;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cls_rf_q <= CLS_NOP;
            cls_ex_q <= CLS_NOP;
        end else begin
            state_q  <= state_d;
            cls_ex_q <= cls_rf_q;
            cls_rf_q <= fresh ? cls_if : CLS_NOP;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, taken_q;
    logic             stall_evt;

    assign stall_evt = bus.beq_if | bus.bne_if | bus.beq_rf | bus.bne_rf | bus.jr_if | bus.lw_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            taken_q <= '0;
        end else begin
            if (stall_evt && !(&stall_q))       stall_q <= stall_q + 1'b1;
            if (bus.br_taken_ex && !(&taken_q)) taken_q <= taken_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.taken_cnt = taken_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.taken_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_pipe_hazard_ctrl;
    import pipe_hazard_pkg::*;

`ifdef PIPE_HAZARD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    localparam logic [31:0] W_ALU = 32'h0022_1820;
    localparam logic [31:0] W_BEQ = 32'h1000_0003;
    localparam logic [31:0] W_BNE = 32'h1400_0003;
    localparam logic [31:0] W_JR  = 32'h03E0_0008;
    localparam logic [31:0] W_LW  = 32'h8C01_0004;
    localparam logic [31:0] W_SW  = 32'hAC01_0004;
    localparam logic [31:0] W_J   = 32'h0800_0010;
    localparam logic [31:0] W_JAL = 32'h0C00_0010;

    localparam logic [13:0] X_BEQ_IF = 14'h2000, X_BNE_IF = 14'h1000, X_J_IF   = 14'h0800;
    localparam logic [13:0] X_JAL_IF = 14'h0400, X_JR_IF  = 14'h0200, X_LW_IF  = 14'h0100;
    localparam logic [13:0] X_BEQ_RF = 14'h0080, X_BNE_RF = 14'h0040, X_JR_RF  = 14'h0020;
    localparam logic [13:0] X_BEQ_EX = 14'h0010, X_BNE_EX = 14'h0008, X_BUB    = 14'h0004;
    localparam logic [13:0] X_STALE  = 14'h0002, X_TAKEN  = 14'h0001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of replay still owed, plus the classes that entered RF and EX.
    int   stale_left;
    cls_t m_rf, m_ex;
    int   m_stall, m_taken;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        zero;
        logic [13:0] vec;
        int          stall;
        int          taken;
    } vec_t;

    function automatic logic [13:0] dut_vec();
        return {bus.beq_if, bus.bne_if, bus.j_if, bus.jal_if, bus.jr_if, bus.lw_if,
                bus.beq_rf, bus.bne_rf, bus.jr_rf, bus.beq_ex, bus.bne_ex,
                bus.rf_bubble, bus.if_stale, bus.br_taken_ex};
    endfunction

    function automatic cls_t ref_class(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h04) return CLS_BEQ;
        if (op == 6'h05) return CLS_BNE;
        if (op == 6'h02) return CLS_J;
        if (op == 6'h03) return CLS_JAL;
        if (op == 6'h23) return CLS_LW;
        if (op == 6'h2B) return CLS_SW;
        if (op == 6'h00 && w[5:0] == 6'h08) return CLS_JR;
        return CLS_ALU;
    endfunction

    function automatic logic [13:0] model_vec();
        logic [13:0] v;
        logic        fresh;
        cls_t        c;
        v     = '0;
        fresh = bus.if_valid && (stale_left == 0);
        c     = ref_class(bus.inst_if);
        if (fresh) begin
            if (c == CLS_BEQ) v |= X_BEQ_IF;
            if (c == CLS_BNE) v |= X_BNE_IF;
            if (c == CLS_J)   v |= X_J_IF;
            if (c == CLS_JAL) v |= X_JAL_IF;
            if (c == CLS_JR)  v |= X_JR_IF;
            if (c == CLS_LW)  v |= X_LW_IF;
        end else begin
            v |= X_BUB;
        end
        if (stale_left != 0) v |= X_STALE;
        if (m_rf == CLS_BEQ) v |= X_BEQ_RF;
        if (m_rf == CLS_BNE) v |= X_BNE_RF;
        if (m_rf == CLS_JR)  v |= X_JR_RF;
        if (m_ex == CLS_BEQ) v |= X_BEQ_EX;
        if (m_ex == CLS_BNE) v |= X_BNE_EX;
        if ((m_ex == CLS_BEQ && bus.alu_zero_ex) || (m_ex == CLS_BNE && !bus.alu_zero_ex)) v |= X_TAKEN;
        return v;
    endfunction

    task automatic model_reset();
        stale_left = 0;
        m_rf = CLS_NOP;
        m_ex = CLS_NOP;
        m_stall = 0;
        m_taken = 0;
    endtask

    task automatic model_step();
        logic [13:0] v;
        logic        fresh;
        cls_t        c;
        v     = model_vec();
        fresh = bus.if_valid && (stale_left == 0);
        c     = ref_class(bus.inst_if);
        if (STATS != 0) begin
            if ((v & (X_BEQ_IF | X_BNE_IF | X_BEQ_RF | X_BNE_RF | X_JR_IF | X_LW_IF)) != 0)
                m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
            if ((v & X_TAKEN) != 0)
                m_taken = (m_taken < 65535) ? m_taken + 1 : m_taken;
        end
        m_ex = m_rf;
        m_rf = fresh ? c : CLS_NOP;
        if (stale_left != 0)                         stale_left = stale_left - 1;
        else if (fresh && (c == CLS_BEQ || c == CLS_BNE)) stale_left = 2;
        else if (fresh && (c == CLS_JR || c == CLS_LW))   stale_left = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs (called at posedge+1), checks at the falling edge, then advances.
    task automatic cycle(input logic [31:0] w, input logic v, input logic z,
                         input bit use_tab, input vec_t row, input string tag);
        bus.inst_if     = w;
        bus.if_valid    = v;
        bus.alu_zero_ex = z;
        @(negedge clk);
        check({tag, " strobes/model"}, {18'd0, dut_vec()}, {18'd0, model_vec()});
        check({tag, " stall_cnt/model"}, {16'd0, bus.stall_cnt}, m_stall);
        check({tag, " taken_cnt/model"}, {16'd0, bus.taken_cnt}, m_taken);
        if (use_tab) begin
            check({tag, " strobes/table"}, {18'd0, dut_vec()}, {18'd0, row.vec});
            check({tag, " stall_cnt/table"}, {16'd0, bus.stall_cnt}, row.stall * STATS);
            check({tag, " taken_cnt/table"}, {16'd0, bus.taken_cnt}, row.taken * STATS);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 8))
            0, 1: op = 6'h00;
            2:    op = 6'h02;
            3:    op = 6'h03;
            4:    op = 6'h04;
            5:    op = 6'h05;
            6:    op = 6'h23;
            7:    op = 6'h2B;
            default: op = 6'($urandom);
        endcase
        w[31:26] = op;
        if (op == 6'h00 && $urandom_range(0, 1) == 1) w[5:0] = 6'h08;
        return w;
    endfunction

    vec_t tab[19];
    vec_t none;

    initial begin
        tab[0]  = '{W_ALU, 1'b1, 1'b0, 14'h0,                          0, 0};
        tab[1]  = '{W_BEQ, 1'b1, 1'b0, X_BEQ_IF,                       0, 0};
        tab[2]  = '{W_BEQ, 1'b1, 1'b0, X_BEQ_RF | X_BUB | X_STALE,     1, 0};
        tab[3]  = '{W_BEQ, 1'b1, 1'b1, X_BEQ_EX | X_BUB | X_STALE | X_TAKEN, 2, 0};
        tab[4]  = '{W_ALU, 1'b1, 1'b1, 14'h0,                          2, 1};
        tab[5]  = '{W_BNE, 1'b1, 1'b0, X_BNE_IF,                       2, 1};
        tab[6]  = '{W_BNE, 1'b1, 1'b0, X_BNE_RF | X_BUB | X_STALE,     3, 1};
        tab[7]  = '{W_BNE, 1'b1, 1'b1, X_BNE_EX | X_BUB | X_STALE,     4, 1};
        tab[8]  = '{W_JR,  1'b1, 1'b0, X_JR_IF,                        4, 1};
        tab[9]  = '{W_JR,  1'b1, 1'b0, X_JR_RF | X_BUB | X_STALE,      5, 1};
        tab[10] = '{W_ALU, 1'b1, 1'b0, 14'h0,                          5, 1};
        tab[11] = '{W_LW,  1'b1, 1'b0, X_LW_IF,                        5, 1};
        tab[12] = '{W_J,   1'b1, 1'b0, X_BUB | X_STALE,                6, 1};
        tab[13] = '{W_J,   1'b1, 1'b0, X_J_IF,                         6, 1};
        tab[14] = '{W_JAL, 1'b1, 1'b0, X_JAL_IF,                       6, 1};
        tab[15] = '{W_ALU, 1'b0, 1'b0, X_BUB,                          6, 1};
        tab[16] = '{W_SW,  1'b1, 1'b0, 14'h0,                          6, 1};
        tab[17] = '{W_BEQ, 1'b0, 1'b0, X_BUB,                          6, 1};
        tab[18] = '{W_ALU, 1'b1, 1'b0, 14'h0,                          6, 1};
        none    = '{W_ALU, 1'b1, 1'b0, 14'h0, 0, 0};

        rst_n           = 1'b0;
        bus.inst_if     = W_ALU;
        bus.if_valid    = 1'b0;
        bus.alu_zero_ex = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset idle strobes", {18'd0, dut_vec()}, {18'd0, X_BUB});
        bus.if_valid = 1'b1;
        #1;
        check("reset valid strobes", {18'd0, dut_vec()}, 32'd0);
        check("reset stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        check("reset taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            cycle(tab[i].inst, tab[i].valid, tab[i].zero, 1'b1, tab[i], $sformatf("row%0d", i));

        // Reset lands while the branch sits in RF: nothing of it may reach RF/EX strobes.
        cycle(W_BEQ, 1'b1, 1'b0, 1'b0, none, "abort beq");
        bus.inst_if = W_ALU;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort strobes in reset", {18'd0, dut_vec()}, 32'd0);
        check("abort stall_cnt in reset", {16'd0, bus.stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(W_ALU, 1'b1, 1'b1, 1'b1, none, $sformatf("post-abort%0d", i));

        for (int i = 0; i < 400; i++)
            cycle(rand_word(), ($urandom_range(0, 4) != 0), 1'($urandom), 1'b0, none,
                  $sformatf("rand%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
